// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the Wishbone SRAM responder
package wb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   typedef struct packed {
      logic valid;
      logic is_err;
      logic is_read;
   } resp_tag_t;

   // Out-of-range latency requests are pinned to the nearest legal depth.
   function automatic int clamp_latency(input int lat);
      if (lat < LAT_MIN) return LAT_MIN;
      if (lat > LAT_MAX) return LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/wishbone.sv
// rtl/wishbone.sv - pipelined Wishbone bus bundle with master and slave modports
interface wishbone #(
   parameter int AW   = 30,
   parameter int DW   = 32,
   parameter int SELW = 4
);
   logic            cyc;
   logic            stb;
   logic            we;
   logic [SELW-1:0] sel;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   mosi_data;
   logic [DW-1:0]   miso_data;
   logic            ack;
   logic            err;
   logic            stall;

   modport slave (
      input  cyc, stb, we, sel, addr, mosi_data,
      output ack, err, stall, miso_data
   );

   modport master (
      output cyc, stb, we, sel, addr, mosi_data,
      input  ack, err, stall, miso_data
   );
endinterface

// File: rtl/wb_resp_pipe.sv
// rtl/wb_resp_pipe.sv - fixed-depth response tag/read-data shift register with bus-drop flush
module wb_resp_pipe
   import wb_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int DW      = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_flush,
   input  resp_tag_t     i_tag,
   input  logic [DW-1:0] i_data,
   output resp_tag_t     o_tag,
   output logic [DW-1:0] o_data
);

   resp_tag_t     r_tag  [LATENCY];
   logic [DW-1:0] r_data [LATENCY];

   // Shift one stage per cycle; a flush empties every stage so dropped cycles never answer.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else if (i_flush) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_tag[i]  <= '0;
            r_data[i] <= '0;
         end
      end else begin
         r_tag[0]  <= i_tag;
         r_data[0] <= i_data;
         for (int i = 1; i < LATENCY; i++) begin
            r_tag[i]  <= r_tag[i-1];
            r_data[i] <= r_data[i-1];
         end
      end
   end

   assign o_tag  = r_tag[LATENCY-1];
   assign o_data = r_data[LATENCY-1];

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - pipelined Wishbone SRAM responder; WB_SRAM_CLEAR_EN zero-fills memory after reset
module wb_sram_slave
   import wb_pkg::*;
#(
   parameter int AW        = 30,
   parameter int DW        = 32,
   parameter int SELW      = 4,
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 2
) (
   input  logic   i_clk,
   input  logic   i_reset,
   wishbone.slave bus
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int LAT   = clamp_latency(LATENCY);

   state_t           r_state;
   state_t           w_next_state;
   logic             w_stall;
   logic             w_init_done;
   logic             w_accept;
   logic             w_in_range;
   logic             w_wr_en;
   logic             w_ack;
   logic             w_err;
   logic [AW-1:0]    w_addr;
   logic [IDX_W-1:0] w_idx;
   logic [DW-1:0]    w_mem_rd;
   logic [DW-1:0]    w_pipe_in_data;
   logic [DW-1:0]    w_pipe_data;
   resp_tag_t        w_pipe_in_tag;
   resp_tag_t        w_pipe_tag;

   logic [DW-1:0]    r_mem [MEM_WORDS];

   assign w_addr     = bus.addr;
   assign w_idx      = w_addr[IDX_W-1:0];
   assign w_in_range = ((w_addr >> IDX_W) == '0);
   assign w_accept   = bus.cyc && bus.stb && !w_stall;
   assign w_wr_en    = w_accept && bus.we && w_in_range;
   assign w_mem_rd   = r_mem[w_idx];

   // State register: reset always returns to INIT.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and stall: requests are held off for the whole of INIT.
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b1;
      case (r_state)
         ST_INIT: begin
            w_stall = 1'b1;
            if (w_init_done) begin
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            w_stall = 1'b0;
         end
         default: begin
            w_next_state = ST_INIT;
         end
      endcase
   end

`ifdef WB_SRAM_CLEAR_EN
   logic [IDX_W-1:0] r_init_cnt;

   assign w_init_done = (r_init_cnt == IDX_W'(MEM_WORDS - 1));

   // Clear address walks 0..MEM_WORDS-1 once per cycle while in INIT.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_init_cnt <= '0;
      end else if (r_state == ST_INIT) begin
         r_init_cnt <= r_init_cnt + IDX_W'(1);
      end
   end

   // Memory write port: zero-fill during INIT (any word touched while reset is held is re-cleared anyway), byte-lane writes in RUN.
   always_ff @(posedge i_clk) begin
      if (r_state == ST_INIT) begin
         r_mem[r_init_cnt] <= '0;
      end else if (w_wr_en) begin
         for (int i = 0; i < SELW; i++) begin
            if (bus.sel[i]) begin
               r_mem[w_idx][8*i +: 8] <= bus.mosi_data[8*i +: 8];
            end
         end
      end
   end
`else
   assign w_init_done = 1'b1;

   // Memory write port: byte-lane writes of accepted in-range requests.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < SELW; i++) begin
            if (bus.sel[i]) begin
               r_mem[w_idx][8*i +: 8] <= bus.mosi_data[8*i +: 8];
            end
         end
      end
   end
`endif

   // Build the response tag and snapshot read data at the acceptance edge.
   always_comb begin
      w_pipe_in_tag         = '0;
      w_pipe_in_data        = '0;
      w_pipe_in_tag.valid   = w_accept;
      w_pipe_in_tag.is_err  = w_accept && !w_in_range;
      w_pipe_in_tag.is_read = w_accept && !bus.we;
      if (w_accept && !bus.we && w_in_range) begin
         w_pipe_in_data = w_mem_rd;
      end
   end

   wb_resp_pipe #(
      .LATENCY (LAT),
      .DW      (DW)
   ) u_resp_pipe (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (!bus.cyc),
      .i_tag   (w_pipe_in_tag),
      .i_data  (w_pipe_in_data),
      .o_tag   (w_pipe_tag),
      .o_data  (w_pipe_data)
   );

   assign w_ack         = bus.cyc && w_pipe_tag.valid && !w_pipe_tag.is_err;
   assign w_err         = bus.cyc && w_pipe_tag.valid && w_pipe_tag.is_err;
   assign bus.ack       = w_ack;
   assign bus.err       = w_err;
   assign bus.stall     = w_stall;
   assign bus.miso_data = (w_ack && w_pipe_tag.is_read) ? w_pipe_data : '0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - self-checking bench for wb_sram_slave (honours WB_SRAM_CLEAR_EN)
module tb_wb_sram_slave;

   localparam int LAT = 2;
   localparam int NV  = 16;
`ifdef WB_SRAM_CLEAR_EN
   localparam int EXP_INIT = 1024;
`else
   localparam int EXP_INIT = 1;
`endif

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic        is_err;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cycle = 0;
   int   checks = 0;
   int   failures = 0;
   int   resp_seen = 0;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[NV];

   wishbone #(.AW(30), .DW(32), .SELW(4)) wb_if ();

   wb_sram_slave #(
      .AW(30), .DW(32), .SELW(4), .MEM_WORDS(1024), .LATENCY(LAT)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (wb_if.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Response monitor: every ack/err is matched in order against the scoreboard, including its cycle.
   always @(negedge clk) begin
      if (wb_if.ack || wb_if.err) begin
         resp_seen++;
         chk("ack_err_exclusive", 64'(wb_if.ack & wb_if.err), 64'd0);
         chk("resp_cyc_high", 64'(wb_if.cyc), 64'd1);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp actual ack=%0b err=%0b at cycle %0d required none", wb_if.ack, wb_if.err, cycle);
         end else begin
            mon_e = sb.pop_front();
            chk("resp_kind_err", 64'(wb_if.err), 64'(mon_e.is_err));
            chk("resp_data", 64'(wb_if.miso_data), 64'(mon_e.data));
            chk("resp_cycle", 64'(cycle), 64'(mon_e.due));
         end
      end else if (sb.size() != 0 && sb[0].due <= cycle) begin
         checks++;
         failures++;
         $display("FAIL missing_resp actual none at cycle %0d required response due %0d", cycle, sb[0].due);
         void'(sb.pop_front());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [29:0] a, input logic [3:0] s, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_data);
      exp_t e;
      wb_if.cyc       = 1'b1;
      wb_if.stb       = 1'b1;
      wb_if.we        = we;
      wb_if.addr      = a;
      wb_if.sel       = s;
      wb_if.mosi_data = d;
      e.is_err = e_err;
      e.data   = e_data;
      e.due    = cycle + LAT;   // accepted at the next edge, visible LAT-1 edges later
      sb.push_back(e);
      step();
      wb_if.stb = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      wb_if.stb = 1'b0;
      while (sb.size() != 0 && n < 20) begin
         step();
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic wait_init(output int n);
      n = 0;
      @(negedge clk);
      while (wb_if.stall && n < 5000) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen0;

      vecs[0]  = '{1'b1, 30'd0,          4'hF, 32'h11111111, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 30'd1,          4'hF, 32'hFFFFFFFF, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 30'd2,          4'hF, 32'h02020202, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 30'd3,          4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 30'd3,          4'h1, 32'h000000AA, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, 30'd3,          4'hF, 32'h0,        1'b0, 32'hDEADBEAA};
      vecs[6]  = '{1'b1, 30'd1,          4'h6, 32'h12345678, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 30'd1024,       4'hF, 32'h12345678, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 30'd0,          4'hF, 32'h0,        1'b0, 32'h11111111};
      vecs[9]  = '{1'b0, 30'd1,          4'hF, 32'h0,        1'b0, 32'hFF3456FF};
      vecs[10] = '{1'b0, 30'd2,          4'hF, 32'h0,        1'b0, 32'h02020202};
      vecs[11] = '{1'b0, 30'd3,          4'hF, 32'h0,        1'b0, 32'hDEADBEAA};
      vecs[12] = '{1'b0, 30'd1024,       4'hF, 32'h0,        1'b1, 32'h0};
      vecs[13] = '{1'b1, 30'h3FFFFFFF,   4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
      vecs[14] = '{1'b1, 30'd1023,       4'hF, 32'hCAFEF00D, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 30'd1023,       4'hF, 32'h0,        1'b0, 32'hCAFEF00D};

      wb_if.cyc = 1'b0;
      wb_if.stb = 1'b0;
      wb_if.we = 1'b0;
      wb_if.sel = 4'h0;
      wb_if.addr = '0;
      wb_if.mosi_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ack", 64'(wb_if.ack), 64'd0);
      chk("reset_err", 64'(wb_if.err), 64'd0);
      chk("reset_stall", 64'(wb_if.stall), 64'd1);
      chk("reset_miso", 64'(wb_if.miso_data), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_init(n);
      chk("init_stall_cycles", 64'(n), 64'(EXP_INIT));
      wb_if.cyc = 1'b1;
`ifdef WB_SRAM_CLEAR_EN
      issue(1'b0, 30'd5, 4'hF, 32'h0, 1'b0, 32'h0);
      drain();
`endif

      // Table: back-to-back requests, every response checked by the monitor
      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
      end
      drain();

      // Table reads again with an idle cycle between requests
      for (int i = 0; i < NV; i++) begin
         if (!vecs[i].we) begin
            issue(1'b0, vecs[i].addr, vecs[i].sel, 32'h0, vecs[i].exp_err, vecs[i].exp_rdata);
            step();
         end
      end
      drain();

      // Two reads accepted, then cyc dropped: nothing may answer
      seen0 = resp_seen;
      issue(1'b0, 30'd0, 4'hF, 32'h0, 1'b0, 32'h11111111);
      issue(1'b0, 30'd1, 4'hF, 32'h0, 1'b0, 32'hFF3456FF);
      wb_if.cyc = 1'b0;
      sb.delete();
      repeat (4) step();
      chk("cyc_drop_no_resp", 64'(resp_seen - seen0), 64'd0);
      wb_if.cyc = 1'b1;
      issue(1'b0, 30'd2, 4'hF, 32'h0, 1'b0, 32'h02020202);
      drain();

      // Reset one cycle after a read is accepted
      issue(1'b0, 30'd3, 4'hF, 32'h0, 1'b0, 32'hDEADBEAA);
      rst = 1'b1;
      sb.delete();
      seen0 = resp_seen;
      #1;
      chk("midreset_stall", 64'(wb_if.stall), 64'd1);
      chk("midreset_ack", 64'(wb_if.ack), 64'd0);
      wb_if.cyc = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      wait_init(n);
      chk("init_stall_cycles_2", 64'(n), 64'(EXP_INIT));
      chk("midreset_no_resp", 64'(resp_seen - seen0), 64'd0);
      wb_if.cyc = 1'b1;
`ifdef WB_SRAM_CLEAR_EN
      issue(1'b0, 30'd3, 4'hF, 32'h0, 1'b0, 32'h0);
`else
      issue(1'b0, 30'd3, 4'hF, 32'h0, 1'b0, 32'hDEADBEAA);
`endif
      drain();

      wb_if.cyc = 1'b0;
      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
